// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/data memory arbiter.
// Holds FSM states, requester ids and counter widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // MEM_LAT is at most 7, so counting 0..MEM_LAT-1 fits in 3 bits.
  localparam int LAT_W = 3;

  // STARVE_MAX is at most 15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: request, response and memory-side signals of mem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid,
    input  if_addr,
    input  d_req_valid,
    input  d_addr,
    input  d_we,
    input  d_wdata,
    input  d_funct3,
    input  mem_rdata,
    output if_req_ready,
    output if_rsp_valid,
    output if_rsp_data,
    output d_req_ready,
    output d_rsp_valid,
    output d_rsp_data,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_funct3
  );

  modport master (
    output if_req_valid,
    output if_addr,
    output d_req_valid,
    output d_addr,
    output d_we,
    output d_wdata,
    output d_funct3,
    output mem_rdata,
    input  if_req_ready,
    input  if_rsp_valid,
    input  if_rsp_data,
    input  d_req_ready,
    input  d_rsp_valid,
    input  d_rsp_data,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_funct3
  );

endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks fetch or data from the two valids.
// Ports: clk, rst_n, if_valid, d_valid, last_gnt, hs in; gnt_any, gnt_id out.
// MEM_ARB_RR_EN: round-robin; otherwise data-first with starvation guard.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    if_valid,
  input  logic    d_valid,
  input  req_id_e last_gnt,
  input  logic    hs,
  output logic    gnt_any,
  output req_id_e gnt_id
);

  logic [STARVE_W-1:0] starve_q;

`ifdef MEM_ARB_RR_EN

  always_comb begin
    gnt_any = if_valid | d_valid;
    gnt_id  = REQ_IF;
    if (if_valid && d_valid) begin
      if (last_gnt == REQ_IF) gnt_id = REQ_D;
      else                    gnt_id = REQ_IF;
    end else if (d_valid) begin
      gnt_id = REQ_D;
    end
  end

  assign starve_q = '0;

  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, hs, starve_q,
                       STARVE_W'(STARVE_MAX)};

`else

  logic starved;
  assign starved = (starve_q == STARVE_W'(STARVE_MAX));

  // Data wins unless fetch has waited STARVE_MAX data grants.
  always_comb begin
    gnt_any = if_valid | d_valid;
    gnt_id  = REQ_IF;
    if (d_valid && !(if_valid && starved))
      gnt_id = REQ_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!if_valid) begin
      starve_q <= '0;
    end else if (hs) begin
      if (gnt_id == REQ_IF)
        starve_q <= '0;
      else if (!starved)
        starve_q <= starve_q + STARVE_W'(1);
    end
  end

  logic unused_last;
  assign unused_last = last_gnt;

`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store.
// Ports: clk, rst_n (async, active-low), bus (mem_arb_if.slave).
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic     clk,
  input logic     rst_n,
  mem_arb_if.slave bus
);

  state_e            state_q;
  state_e            state_d;
  req_id_e           gnt_q;
  req_id_e           gnt_id;
  logic              gnt_any;
  logic              open_win;
  logic              hs;
  logic              lat_last;
  logic [LAT_W-1:0]  lat_q;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [2:0]        mem_funct3_q;
  logic              if_rsp_valid_q;
  logic [DATA_W-1:0] if_rsp_data_q;
  logic              d_rsp_valid_q;
  logic [DATA_W-1:0] d_rsp_data_q;

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (bus.if_req_valid),
    .d_valid  (bus.d_req_valid),
    .last_gnt (gnt_q),
    .hs       (hs),
    .gnt_any  (gnt_any),
    .gnt_id   (gnt_id)
  );

  // rst_n gating keeps ready low while reset is held.
  assign open_win = rst_n &
                    ((state_q == IDLE) |
                     (state_q == RESP));
  assign hs       = open_win & gnt_any;
  assign lat_last = (lat_q == LAT_W'(MEM_LAT - 1));

  always_comb begin
    bus.if_req_ready = 1'b0;
    bus.d_req_ready  = 1'b0;
    if (hs) begin
      if (gnt_id == REQ_IF) bus.if_req_ready = 1'b1;
      else                  bus.d_req_ready  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    if (lat_last) state_d = RESP;
      RESP:    state_d = hs ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Payload latch, latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q          <= REQ_IF;
      lat_q          <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_funct3_q   <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= '0;
    end else begin
      mem_en_q       <= hs;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;

      if (hs) begin
        gnt_q <= gnt_id;
        if (gnt_id == REQ_IF) begin
          mem_we_q     <= 1'b0;
          mem_addr_q   <= bus.if_addr;
          mem_wdata_q  <= '0;
          mem_funct3_q <= FUNCT3_WORD;
        end else begin
          mem_we_q     <= bus.d_we;
          mem_addr_q   <= bus.d_addr;
          mem_wdata_q  <= bus.d_wdata;
          mem_funct3_q <= bus.d_funct3;
        end
      end

      if (state_q == ACCESS)
        lat_q <= '0;
      else if (state_q == WAIT)
        lat_q <= lat_q + LAT_W'(1);

      if (state_q == WAIT && lat_last) begin
        if (gnt_q == REQ_IF) begin
          if_rsp_valid_q <= 1'b1;
          if_rsp_data_q  <= bus.mem_rdata;
        end else begin
          d_rsp_valid_q <= 1'b1;
          d_rsp_data_q  <= mem_we_q ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_funct3   = mem_funct3_q;
  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.d_rsp_valid  = d_rsp_valid_q;
  assign bus.d_rsp_data   = d_rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// Two instances: MEM_LAT=1 (u_dut) and MEM_LAT=3 (u_dut3).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)
  ) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] pipe1;
  always @(posedge clk) begin
    if (b1.mem_en) begin
      if (b1.mem_we) begin
        mem1[b1.mem_addr] = b1.mem_wdata;
        pipe1 <= 32'h0;
      end else begin
        pipe1 <= mem1.exists(b1.mem_addr) ? mem1[b1.mem_addr] : 32'h0;
      end
    end
  end
  assign b1.mem_rdata = pipe1;

  logic [31:0] rd3;
  logic [31:0] p3 [3];
  always_comb begin
    rd3 = 32'h0;
    if (b3.mem_addr == 32'h8000) rd3 = 32'h00500093;
    if (b3.mem_addr == 32'h8004) rd3 = 32'h00A00113;
  end
  always @(posedge clk) begin
    p3[0] <= b3.mem_en ? rd3 : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b3.mem_rdata = p3[2];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] gord;
  logic [9:0] exp_g;
  int ng;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    b1.if_req_valid = 0; b1.if_addr = 0;
    b1.d_req_valid = 0; b1.d_addr = 0; b1.d_we = 0;
    b1.d_wdata = 0; b1.d_funct3 = 0;
    b3.if_req_valid = 0; b3.if_addr = 0;
    b3.d_req_valid = 0; b3.d_addr = 0; b3.d_we = 0;
    b3.d_wdata = 0; b3.d_funct3 = 0;
    mem1[32'h8000] = 32'h00500093;
    gord = '0;
`ifdef MEM_ARB_RR_EN
    exp_g = 10'b0101010101;
`else
    exp_g = 10'b0111101111;
`endif

    // reset state, ready held low even with a request pending
    #12;
    b1.if_req_valid = 1;
    #1;
    chk("rst_mem", {b1.mem_en, b1.mem_we, b1.mem_funct3,
                    b1.mem_addr}, 0);
    chk("rst_wdata", b1.mem_wdata, 0);
    chk("rst_rsp", {b1.if_rsp_valid, b1.d_rsp_valid}, 0);
    chk("rst_rdata", {b1.if_rsp_data, b1.d_rsp_data}, 0);
    chk("rst_ready", {b1.if_req_ready, b1.d_req_ready}, 0);
    b1.if_req_valid = 0;
    tick();
    rst_n = 1'b1;

    // single fetch, MEM_LAT=1
    tick();
    b1.if_req_valid = 1; b1.if_addr = 32'h8000;
    #1;
    chk("f_if_ready", b1.if_req_ready, 1);
    chk("f_d_ready", b1.d_req_ready, 0);
    tick();
    b1.if_req_valid = 0; b1.if_addr = 0;
    #1;
    chk("f_mem_en", b1.mem_en, 1);
    chk("f_mem_addr", b1.mem_addr, 32'h8000);
    chk("f_mem_we", b1.mem_we, 0);
    chk("f_mem_f3", b1.mem_funct3, 3'b010);
    tick(); #1;
    chk("f_wait_en", b1.mem_en, 0);
    chk("f_wait_rsp", b1.if_rsp_valid, 0);
    tick(); #1;
    chk("f_rsp_v", b1.if_rsp_valid, 1);
    chk("f_rsp_d", b1.if_rsp_data, 32'h00500093);
    chk("f_drsp_v", b1.d_rsp_valid, 0);
    tick();

    // store then load
    b1.d_req_valid = 1; b1.d_we = 1; b1.d_addr = 32'h100;
    b1.d_wdata = 32'hDEADBEEF; b1.d_funct3 = 3'd2;
    #1;
    chk("f_rsp_pulse", b1.if_rsp_valid, 0);
    chk("f_rsp_hold", b1.if_rsp_data, 32'h00500093);
    chk("s_d_ready", b1.d_req_ready, 1);
    chk("s_if_ready", b1.if_req_ready, 0);
    tick();
    b1.d_req_valid = 0;
    #1;
    chk("s_mem", {b1.mem_en, b1.mem_we, b1.mem_funct3}, 5'b11010);
    chk("s_addr", b1.mem_addr, 32'h100);
    chk("s_wdata", b1.mem_wdata, 32'hDEADBEEF);
    tick(); tick();
    b1.d_we = 0; b1.d_wdata = 0;
    #1;
    chk("s_ack", b1.d_rsp_valid, 1);
    chk("s_ack_d", b1.d_rsp_data, 0);
    b1.d_req_valid = 1;
    #1;
    chk("l_ready_resp", b1.d_req_ready, 1);
    tick();
    b1.d_req_valid = 0;
    #1;
    chk("l_mem", {b1.mem_en, b1.mem_we}, 2'b10);
    chk("l_ack_pulse", b1.d_rsp_valid, 0);
    tick(); tick(); #1;
    chk("l_rsp_v", b1.d_rsp_valid, 1);
    chk("l_rsp_d", b1.d_rsp_data, 32'hDEADBEEF);

    // contention from a fresh reset
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    b1.if_req_valid = 1; b1.if_addr = 32'h8000;
    b1.d_req_valid = 1; b1.d_we = 0; b1.d_addr = 32'h100;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      #1;
      chk("one_ready", b1.if_req_ready & b1.d_req_ready, 0);
      if (b1.d_req_ready) begin
        gord[ng] = 1'b1; ng++;
      end else if (b1.if_req_ready) begin
        gord[ng] = 1'b0; ng++;
      end
      tick();
    end
    b1.if_req_valid = 0; b1.d_req_valid = 0;
    chk("grant_cnt", ng, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_%0d", i), gord[i], exp_g[i]);
    tick(); tick(); tick(); tick();

    // MEM_LAT=3 back-to-back fetches
    b3.if_req_valid = 1; b3.if_addr = 32'h8000;
    #1;
    chk("l3_ready0", b3.if_req_ready, 1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) b3.if_addr = 32'h8004;
      if (c == 6) begin
        b3.if_req_valid = 0; b3.if_addr = 0;
      end
      #1;
      chk($sformatf("l3_en_%0d", c), b3.mem_en,
          64'(c == 1 || c == 6));
      chk($sformatf("l3_rsp_%0d", c), b3.if_rsp_valid,
          64'(c == 5 || c == 10));
      if (c == 5) begin
        chk("l3_d0", b3.if_rsp_data, 32'h00500093);
        chk("l3_ready1", b3.if_req_ready, 1);
      end
      if (c == 6) chk("l3_addr1", b3.mem_addr, 32'h8004);
      if (c == 10) chk("l3_d1", b3.if_rsp_data, 32'h00A00113);
    end

    // reset during WAIT of a load
    tick();
    b1.d_req_valid = 1; b1.d_we = 0; b1.d_addr = 32'h100;
    #1;
    chk("r_d_ready", b1.d_req_ready, 1);
    tick();
    b1.d_req_valid = 0;
    #1;
    chk("r_acc", b1.mem_en, 1);
    tick(); #1;
    rst_n = 1'b0;
    #1;
    chk("r_mem", {b1.mem_en, b1.mem_we, b1.mem_addr}, 0);
    chk("r_rsp", {b1.if_rsp_valid, b1.d_rsp_valid}, 0);
    chk("r_ddata", b1.d_rsp_data, 0);
    chk("r_idata", b1.if_rsp_data, 0);
    tick(); #1;
    chk("r_no_rsp", b1.d_rsp_valid, 0);
    rst_n = 1'b1;
    tick();
    b1.if_req_valid = 1; b1.if_addr = 32'h8000;
    #1;
    chk("r2_ready", b1.if_req_ready, 1);
    tick();
    b1.if_req_valid = 0;
    #1;
    chk("r2_mem", {b1.mem_en, b1.mem_addr}, {1'b1, 32'h8000});
    tick(); tick(); #1;
    chk("r2_rsp_v", b1.if_rsp_valid, 1);
    chk("r2_rsp_d", b1.if_rsp_data, 32'h00500093);
    chk("r2_drsp", b1.d_rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
